matrix_multiply_engine: RTL
===========================

Name: matrix_multiply_engine

Overview:
- Successor to the fixed-size matrix-multiply top: computes Z = X·Y, or Z = Z + X·Y, over runtime-configured dimensions M×K by K×N.
- Uses three internal single-port synchronous RAMs (X, Y, Z) and one host load/readback port.
- Sits behind the DFR system's register interface. Software preloads X/Y, pulses start, polls busy/done, then reads back Z.

Parameters:
- ADDR_WIDTH, 32, host address width; only the low AW bits are used.
- DATA_WIDTH, 32, signed element width.
- MEM_DEPTH, 64, words per RAM; AW = $clog2(MEM_DEPTH).
- DIM_WIDTH, 8, width of each dimension config field.
- FRAC_BITS, 0, fixed-point fraction bits; the result is arithmetically right-shifted by this amount.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle start request
- cfg_m  in  DIM_WIDTH  X rows (M)
- cfg_k  in  DIM_WIDTH  X cols = Y rows (K)
- cfg_n  in  DIM_WIDTH  Y cols (N)
- cfg_accum  in  1  1 = Z += X·Y; 0 = Z = X·Y
- ram_addr  in  ADDR_WIDTH  host word address
- ram_wen  in  1  host write enable
- ram_sel  in  2  00 = X, 01 = Y, 10 = Z, 11 = none
- ram_data_in  in  DATA_WIDTH  host write data
- ram_data_out  out  DATA_WIDTH  host read data, one cycle after address
- busy  out  1  computation in progress
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  sticky: last start was rejected

Behaviour:
- Reset (rst=0, async): state IDLE; busy, done and cfg_err = 0; ram_data_out = 0. RAM contents are not cleared.
- Layout is row-major: X[i][k] @ i*K+k, Y[k][j] @ k*N+j, Z[i][j] @ i*N+j.
- Start in IDLE:
  - The config is validated: M, K, N ≠ 0, and M*K, K*N, M*N ≤ MEM_DEPTH.
  - If invalid: cfg_err ← 1, state remains IDLE.
  - If valid: cfg_err ← 0, the config is latched, busy = 1 from the next cycle.
- start while busy is ignored. Config inputs are don't-care after latching.
- States: IDLE → (RDZ if accum) → MAC → WR → next element or DONE → IDLE.
- Element order: i outer, j inner.
- RDZ (1 cycle): issues a Z read at i*N+j.
- MAC (K+1 cycles):
  - Cycle c < K issues X/Y addresses for k = c.
  - Cycle c ≥ 1 accumulates the product that arrived.
  - Accumulator init at cycle 0: Z read data if accum, else 0.
- WR (1 cycle): writes the result to Z[i][j].
- Per-element cost: K+2 cycles, or K+3 with accumulate. busy is high for exactly M*N*(K+2[+1]) cycles.
- DONE: done = 1 for one cycle with busy = 0. The next state is IDLE, and start is accepted on the following cycle.
- Arithmetic:
  - Full-precision signed product of 2*DATA_WIDTH bits.
  - Accumulator of 2*DATA_WIDTH + DIM_WIDTH bits.
  - Result = acc >>> FRAC_BITS, truncated (wrapped) to DATA_WIDTH.
- Host port while busy=0: ram_sel routes address/data/wen to the selected RAM. ram_sel=11 drops writes and reads return 0.
- Host port while busy=1: host writes are dropped and ram_data_out = 0.
- Host address bits above AW are ignored (wrap).
- Reset mid-operation: returns to IDLE immediately. Z may be partially written; no done pulse.

Optional Feature:
- Macro MATMUL_SAT_EN.
- Defined: the shifted result saturates to [-2^(DW-1), 2^(DW-1)-1].
- Undefined: the result wraps on truncation.
- Latency is identical in both builds.

Decomposition:
- Package matmul_pkg holds:
  - state enum (IDLE, RDZ, MAC, WR, DONE);
  - ram_sel constants SEL_X, SEL_Y, SEL_Z, SEL_NONE.
- Sub-module matmul_mac_unit holds:
  - accumulator with clear/load/accumulate controls;
  - shift, plus saturate or wrap output.
- The three RAMs reuse the team's existing single-port ram module.

Test Plan:
- Basic multiply: M=2, K=3, N=2, X=[[1,2,3],[4,5,6]], Y=[[7,8],[9,10],[11,12]], accum=0.
  - Z=[[58,64],[139,154]], busy high 20 cycles, one done pulse.
- Accumulate: same X/Y, Z preloaded with all 1s, accum=1.
  - Z=[[59,65],[140,155]], busy high 24 cycles.
- Config errors:
  - cfg_m=0 → cfg_err=1, busy stays 0, Z unchanged.
  - M=K=N=9 with depth 64 → cfg_err=1.
  - A subsequent valid start clears cfg_err.
- Protocol while busy: start again and host-write X[0]=99 while busy.
  - Both are ignored; results match the basic case; reading Z while busy returns 0.
- Reset mid-run: drop rst at cycle 5 of the basic case.
  - busy, done and cfg_err go to 0 immediately; a restarted run completes correctly.
- Overflow: 1×1×1, X=0x7FFFFFFF, Y=2.
  - Without MATMUL_SAT_EN, Z=0xFFFFFFFE.
  - With it, Z=0x7FFFFFFF.
  - FRAC_BITS=16 with X=Y=0x00010000 gives 0x00010000.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared state encoding and host RAM-select codes for the matrix multiply engine.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RDZ,
        MAC,
        WR,
        DONE
    } state_t;

    localparam logic [1:0] SEL_X    = 2'b00;
    localparam logic [1:0] SEL_Y    = 2'b01;
    localparam logic [1:0] SEL_Z    = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

endpackage

// File: rtl/matmul_mac_unit.sv
// Wide signed multiply-accumulate with fixed-point shift on the output.
// Build option MATMUL_SAT_EN: saturate the shifted result instead of wrapping it.
module matmul_mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int DIM_WIDTH  = 8,
    parameter int FRAC_BITS  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  acc_en,
    input  logic [DATA_WIDTH-1:0] load_val,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int PROD_W = 2 * DATA_WIDTH;
    localparam int ACC_W  = PROD_W + DIM_WIDTH;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;

    assign prod = PROD_W'(signed'(op_a)) * PROD_W'(signed'(op_b));

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (load) begin
            acc_d = ACC_W'(signed'(load_val));
        end else if (acc_en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef MATMUL_SAT_EN
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc_q >>> FRAC_BITS;

    always_comb begin
        result = shifted[DATA_WIDTH-1:0];
        if (shifted > MAX_V) begin
            result = MAX_V[DATA_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            result = MIN_V[DATA_WIDTH-1:0];
        end
    end
`else
    assign result = DATA_WIDTH'(acc_q >>> FRAC_BITS);
`endif

endmodule

// File: rtl/matmul_spram.sv
// Single-port synchronous RAM with registered read (read-before-write).
module matmul_spram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int AW         = 6
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/matrix_multiply_engine.sv
// Runtime-sized Z = X*Y (or Z += X*Y) over three single-port RAMs with a host load/readback port.
// Build option MATMUL_SAT_EN selects a saturating result in the MAC unit.
module matrix_multiply_engine
    import matmul_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int DIM_WIDTH  = 8,
    parameter int FRAC_BITS  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  cfg_m,
    input  logic [DIM_WIDTH-1:0]  cfg_k,
    input  logic [DIM_WIDTH-1:0]  cfg_n,
    input  logic                  cfg_accum,
    input  logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic                  ram_wen,
    input  logic [1:0]            ram_sel,
    input  logic [DATA_WIDTH-1:0] ram_data_in,
    output logic [DATA_WIDTH-1:0] ram_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int LW = 2 * DIM_WIDTH;

    state_t                state_q, state_d;
    logic [DIM_WIDTH-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
    logic [DIM_WIDTH-1:0]  i_q, i_d, j_q, j_d, c_q, c_d;
    logic                  accum_q, accum_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [1:0]            rd_sel_q, rd_sel_d;

    logic                  cfg_ok;
    logic                  mac_clr, mac_load, mac_acc;
    logic [DATA_WIDTH-1:0] mac_result;
    logic [AW-1:0]         host_addr, x_addr_e, y_addr_e, z_addr_e;
    logic [AW-1:0]         x_addr, y_addr, z_addr;
    logic                  x_we, y_we, z_we;
    logic [DATA_WIDTH-1:0] z_wdata, x_rdata, y_rdata, z_rdata;
    logic                  unused_addr_hi;

    assign cfg_ok = (cfg_m != '0) && (cfg_k != '0) && (cfg_n != '0)
                 && (LW'(cfg_m) * LW'(cfg_k) <= LW'(MEM_DEPTH))
                 && (LW'(cfg_k) * LW'(cfg_n) <= LW'(MEM_DEPTH))
                 && (LW'(cfg_m) * LW'(cfg_n) <= LW'(MEM_DEPTH));

    assign busy    = (state_q == RDZ) || (state_q == MAC) || (state_q == WR);
    assign done    = (state_q == DONE);
    assign cfg_err = cfg_err_q;

    // Row-major element addresses; in MAC c_q doubles as the k index being fetched.
    assign x_addr_e = AW'(LW'(i_q) * LW'(k_q) + LW'(c_q));
    assign y_addr_e = AW'(LW'(c_q) * LW'(n_q) + LW'(j_q));
    assign z_addr_e = AW'(LW'(i_q) * LW'(n_q) + LW'(j_q));

    assign host_addr      = ram_addr[AW-1:0];
    assign unused_addr_hi = ^ram_addr[ADDR_WIDTH-1:AW];

    assign x_addr  = busy ? x_addr_e : host_addr;
    assign y_addr  = busy ? y_addr_e : host_addr;
    assign z_addr  = busy ? z_addr_e : host_addr;
    assign x_we    = !busy && ram_wen && (ram_sel == SEL_X);
    assign y_we    = !busy && ram_wen && (ram_sel == SEL_Y);
    assign z_we    = busy ? (state_q == WR) : (ram_wen && (ram_sel == SEL_Z));
    assign z_wdata = busy ? mac_result : ram_data_in;

    assign rd_sel_d = busy ? SEL_NONE : ram_sel;

    always_comb begin
        ram_data_out = '0;
        if (!busy) begin
            case (rd_sel_q)
                SEL_X:   ram_data_out = x_rdata;
                SEL_Y:   ram_data_out = y_rdata;
                SEL_Z:   ram_data_out = z_rdata;
                default: ram_data_out = '0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        k_d       = k_q;
        n_d       = n_q;
        i_d       = i_q;
        j_d       = j_q;
        c_d       = c_q;
        accum_d   = accum_q;
        cfg_err_d = cfg_err_q;
        mac_clr   = 1'b0;
        mac_load  = 1'b0;
        mac_acc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        cfg_err_d = 1'b0;
                        m_d       = cfg_m;
                        k_d       = cfg_k;
                        n_d       = cfg_n;
                        accum_d   = cfg_accum;
                        i_d       = '0;
                        j_d       = '0;
                        c_d       = '0;
                        state_d   = cfg_accum ? RDZ : MAC;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            RDZ: begin
                c_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                // Cycle 0 seeds the accumulator; products arrive one cycle after their fetch.
                mac_clr  = (c_q == '0) && !accum_q;
                mac_load = (c_q == '0) && accum_q;
                mac_acc  = (c_q != '0);
                if (c_q == k_q) begin
                    state_d = WR;
                end else begin
                    c_d = c_q + DIM_WIDTH'(1);
                end
            end
            WR: begin
                c_d     = '0;
                state_d = accum_q ? RDZ : MAC;
                if (j_q == n_q - DIM_WIDTH'(1)) begin
                    j_d = '0;
                    if (i_q == m_q - DIM_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + DIM_WIDTH'(1);
                    end
                end else begin
                    j_d = j_q + DIM_WIDTH'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            k_q       <= '0;
            n_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            c_q       <= '0;
            accum_q   <= 1'b0;
            cfg_err_q <= 1'b0;
            rd_sel_q  <= SEL_NONE;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            k_q       <= k_d;
            n_q       <= n_d;
            i_q       <= i_d;
            j_q       <= j_d;
            c_q       <= c_d;
            accum_q   <= accum_d;
            cfg_err_q <= cfg_err_d;
            rd_sel_q  <= rd_sel_d;
        end
    end

    matmul_spram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH), .AW(AW)) u_ram_x (
        .clk(clk), .we(x_we), .addr(x_addr), .wdata(ram_data_in), .rdata(x_rdata)
    );

    matmul_spram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH), .AW(AW)) u_ram_y (
        .clk(clk), .we(y_we), .addr(y_addr), .wdata(ram_data_in), .rdata(y_rdata)
    );

    matmul_spram #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(MEM_DEPTH), .AW(AW)) u_ram_z (
        .clk(clk), .we(z_we), .addr(z_addr), .wdata(z_wdata), .rdata(z_rdata)
    );

    matmul_mac_unit #(.DATA_WIDTH(DATA_WIDTH), .DIM_WIDTH(DIM_WIDTH), .FRAC_BITS(FRAC_BITS)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .load     (mac_load),
        .acc_en   (mac_acc),
        .load_val (z_rdata),
        .op_a     (x_rdata),
        .op_b     (y_rdata),
        .result   (mac_result)
    );

endmodule
